// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down counter / timer.
// Counts a loaded value down to terminal count, then either stops (one-shot,
// sticky done flag) or reloads itself (periodic tick source). A one-cycle
// tc pulse marks every terminal count.
// Optional feature: define DOWN_COUNTER_PRESCALE_EN to decrement only once
// every PRESCALE clocks while running; without it the count moves every clock.
module down_counter_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // A running edge that is not overridden by load or stop advances time.
    logic run_tick;
    // A fresh launch from IDLE/DONE; distinguishes it from a PAUSE resume.
    logic launch;
    // The edge on which the count actually moves.
    logic dec_event;

    assign run_tick = (state_q == RUN) && !load && !stop;
    assign launch   = !load && start &&
                      (((state_q == IDLE) && (count_q != '0)) ||
                       ((state_q == DONE) && (reload_q != '0)));

`ifdef DOWN_COUNTER_PRESCALE_EN
    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc_q, psc_d;

    assign dec_event = run_tick && (psc_q == PSC_LAST);

    // Prescaler phase: restarts on load or a fresh launch, advances only on
    // running edges, and simply holds while paused so a pause stretches the
    // current interval by exactly its length.
    always_comb begin
        psc_d = psc_q;
        if (load || launch) begin
            psc_d = '0;
        end else if (run_tick) begin
            psc_d = (psc_q == PSC_LAST) ? '0 : psc_q + PSC_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign dec_event = run_tick;
`endif

    // Next-state logic: load beats stop, stop beats start; tc defaults low so
    // it can only ever last a single cycle.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        done_d   = done_q;

        if (load) begin
            reload_d = load_value;
            count_d  = load_value;
            state_d  = IDLE;
            done_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (dec_event) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (count_q == WIDTH'(1)) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                // Zero is never shown in periodic mode.
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                done_d  = 1'b1;
                                state_d = DONE;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (!stop && start) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (launch) begin
                        count_d = reload_q;
                        done_d  = 1'b0;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == RUN) || (state_d == PAUSE);
    end

    // State and output registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: a rule-level model checked every cycle plus
// directed sequences with hand-computed expectations.
module tb_down_counter_timer;

    localparam int WIDTH = 8;
`ifdef DOWN_COUNTER_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             auto_reload = 1'b0;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model state: what the timer "is doing", expressed in plain terms.
    int m_cnt   = 0;
    int m_rel   = 0;
    bit m_run   = 0;
    bit m_pause = 0;
    bit m_done  = 0;
    bit m_tc    = 0;
    int m_clks  = 0;   // clocks spent running since the last count step

    down_counter_timer #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .auto_reload(auto_reload),
        .count      (count),
        .tc         (tc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Model: evaluates each clock edge from the inputs it sampled.
    initial forever begin
        @(posedge clk);
        m_tc = 0;
        if (reset) begin
            m_cnt = 0; m_rel = 0; m_run = 0; m_pause = 0; m_done = 0; m_clks = 0;
        end else if (load) begin
            m_cnt = int'(load_value); m_rel = int'(load_value);
            m_run = 0; m_pause = 0; m_done = 0; m_clks = 0;
        end else if (m_run || m_pause) begin
            if (stop) begin
                m_run = 0; m_pause = 1;
            end else if (m_pause) begin
                if (start) begin m_pause = 0; m_run = 1; end
            end else begin
                m_clks++;
                if (m_clks == P) begin
                    m_clks = 0;
                    if (m_cnt == 1) begin
                        m_tc = 1;
                        if (auto_reload) m_cnt = m_rel;
                        else begin m_cnt = 0; m_run = 0; m_done = 1; end
                    end else begin
                        m_cnt--;
                    end
                end
            end
        end else if (start) begin
            if (m_done && m_rel != 0) begin
                m_cnt = m_rel; m_done = 0; m_run = 1; m_clks = 0;
            end else if (!m_done && m_cnt != 0) begin
                m_run = 1; m_clks = 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("mdl_count", 32'(count), 32'(m_cnt));
            chk("mdl_tc",    32'(tc),    32'(m_tc));
            chk("mdl_busy",  32'(busy),  32'(m_run || m_pause));
            chk("mdl_done",  32'(done),  32'(m_done));
        end
    end

    initial begin
        // Reset held two cycles with noise on load/start.
        reset = 1; load = 1; start = 1; load_value = WIDTH'($urandom_range(1, 255));
        cyc();
        chk_en = 1'b1;
        load_value = WIDTH'($urandom_range(1, 255));
        cyc();
        chk("rst_count", 32'(count), 0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_done",  32'(done),  0);
        chk("rst_tc",    32'(tc),    0);
        reset = 0; load = 0; start = 1;
        cyc();
        chk("start_after_rst_busy",  32'(busy),  0);
        chk("start_after_rst_count", 32'(count), 0);
        start = 0;
        cyc();

`ifndef DOWN_COUNTER_PRESCALE_EN
        // One-shot from 5.
        load = 1; load_value = 8'd5; cyc();
        chk("os_load_count", 32'(count), 5);
        load = 0; auto_reload = 0; start = 1; cyc();
        chk("os_start_busy",  32'(busy),  1);
        chk("os_start_count", 32'(count), 5);
        start = 0;
        for (int i = 4; i >= 0; i--) begin
            cyc();
            chk("os_count", 32'(count), 32'(i));
            chk("os_tc",    32'(tc),    32'(i == 0));
        end
        chk("os_done", 32'(done), 1);
        chk("os_busy", 32'(busy), 0);
        chk("os_model_cnt", 32'(m_cnt), 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("os_hold", 32'(count), 0);
        end
        chk("os_tc_after", 32'(tc), 0);
        // Restart from DONE reloads the saved value.
        start = 1; cyc(); start = 0;
        chk("done_restart_count", 32'(count), 5);
        chk("done_restart_done",  32'(done),  0);
        chk("done_restart_busy",  32'(busy),  1);

        // Periodic with reload 3.
        load = 1; load_value = 8'd3; cyc();
        load = 0; auto_reload = 1; start = 1; cyc(); start = 0;
        chk("per_start_count", 32'(count), 3);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("per_count", 32'(count), 32'(3 - (k % 3)));
            chk("per_tc",    32'(tc),    32'(k % 3 == 0));
            chk("per_done",  32'(done),  0);
        end
        auto_reload = 0;

        // Pause / resume from 10.
        load = 1; load_value = 8'd10; cyc();
        load = 0; start = 1; cyc(); start = 0;
        chk("pr_start", 32'(count), 10);
        cyc(); cyc(); cyc();
        chk("pr_at7", 32'(count), 7);
        stop = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("pr_hold", 32'(count), 7);
            chk("pr_busy", 32'(busy), 1);
        end
        stop = 0; start = 1; cyc(); start = 0;
        chk("pr_resume_edge", 32'(count), 7);
        cyc();
        chk("pr_resume_dec", 32'(count), 6);
        start = 1; stop = 1; cyc(); start = 0; stop = 0;
        chk("pr_both_count", 32'(count), 6);
        cyc();
        chk("pr_both_paused", 32'(count), 6);
        chk("pr_both_busy",   32'(busy),  1);

        // Load mid-run, then reset mid-run.
        start = 1; cyc(); start = 0;
        chk("lm_run_count", 32'(count), 6);
        load = 1; load_value = 8'd9; cyc(); load = 0;
        chk("lm_count", 32'(count), 9);
        chk("lm_busy",  32'(busy),  0);
        chk("lm_tc",    32'(tc),    0);
        start = 1; cyc(); start = 0;
        for (int i = 8; i >= 4; i--) cyc();
        chk("rm_at4", 32'(count), 4);
        reset = 1; start = 1; cyc(); reset = 0; start = 0;
        chk("rm_count", 32'(count), 0);
        chk("rm_busy",  32'(busy),  0);
        chk("rm_done",  32'(done),  0);
        start = 1; cyc(); start = 0;
        chk("rm_start_ignored", 32'(busy), 0);
        cyc();
`else
        // Prescaled one-shot from 2, with a pause mid-interval.
        load = 1; load_value = 8'd2; cyc();
        load = 0; auto_reload = 0; start = 1; cyc(); start = 0;
        chk("ps_start", 32'(count), 2);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("ps_first", 32'(count), (k < 4) ? 32'd2 : 32'd1);
            chk("ps_first_tc", 32'(tc), 0);
        end
        for (int k = 1; k <= 7; k++) begin
            stop  = (k == 2);
            start = (k == 4);
            cyc();
            chk("ps_second", 32'(count), (k < 7) ? 32'd1 : 32'd0);
            chk("ps_second_tc", 32'(tc), 32'(k == 7));
        end
        stop = 0; start = 0;
        cyc();
        chk("ps_tc_one_cycle", 32'(tc), 0);
        chk("ps_done", 32'(done), 1);
        cyc();
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
